// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives pc, buffers {pc, instruction} pairs in a prefetch FIFO.
// Optional FETCH_STATS_EN adds push / redirect counters (stat_fetched, stat_flushes).
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushes,
`endif
  output logic        halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [31:0]         mem_pc_q [DEPTH];
  logic [31:0]         mem_ins_q[DEPTH];
  logic                push, pop;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_valid = (count_q != '0) && !redirect;
    pop       = out_valid && out_ready;
    // Full test uses the registered count: a same-cycle pop never frees a slot for a push.
    push      = (state_q == StRun) && (count_q < DepthCnt) && !redirect;

    if (redirect) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = StRun;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (instruction == HALT_OPCODE) state_d = StHalted;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
      if (state_q == StBoot) state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_pc_q[i]  <= '0;
        mem_ins_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_pc_q[wr_ptr_q]  <= pc_q;
        mem_ins_q[wr_ptr_q] <= instruction;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      flushes_q <= '0;
    end else begin
      if (push)     fetched_q <= fetched_q + 32'd1;
      if (redirect) flushes_q <= flushes_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushes = flushes_q;
`endif

  assign pc        = pc_q;
  assign out_pc    = mem_pc_q[rd_ptr_q];
  assign out_instr = mem_ins_q[rd_ptr_q];
  assign halted    = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus,
// all checked against a queue-based reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, redirect, out_ready;
  logic [31:0] redirect_pc, instruction;
  logic [31:0] pc, out_pc, out_instr;
  logic        out_valid, halted;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushes;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
`ifdef FETCH_STATS_EN
    .stat_fetched(stat_fetched),
    .stat_flushes(stat_flushes),
`endif
    .halted      (halted)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;

  ent_t        mq[$];
  int          m_mode;   // 0 boot, 1 run, 2 halted
  logic [31:0] m_pc;
  bit          m_zero;   // head registers still hold their reset value
  logic [31:0] halt_addr = 32'h1;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a == halt_addr) ? 32'hFFFF_FFFF : (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit rdir, input logic [31:0] rpc, input bit rdy,
                      input bit chk);
    bit exp_v, do_push;
    @(negedge clk);
    reset       = rst;
    redirect    = rdir;
    redirect_pc = rpc;
    out_ready   = rdy;
    instruction = imem(pc);
    #1;
    exp_v = (mq.size() != 0) && !rdir;
    if (chk) begin
      check("pc", pc, m_pc);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      check("halted", {31'b0, halted}, {31'b0, m_mode == 2});
      if (exp_v) begin
        check("out_pc", out_pc, mq[0].pc);
        check("out_instr", out_instr, mq[0].ins);
      end else if (m_zero) begin
        check("out_pc_rst", out_pc, 32'h0);
        check("out_instr_rst", out_instr, 32'h0);
      end
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_mode = 0;
      m_pc   = 32'h0;
      m_zero = 1'b1;
    end else if (rdir) begin
      mq.delete();
      m_mode = 1;
      m_pc   = rpc & 32'hFFFF_FFFC;
    end else begin
      do_push = (m_mode == 1) && (mq.size() < 4);
      if (exp_v && rdy) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: m_pc, ins: instruction});
        m_pc   = m_pc + 32'd4;
        m_zero = 1'b0;
        if (instruction == 32'hFFFF_FFFF) m_mode = 2;
      end
      if (m_mode == 0) m_mode = 1;
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, rdy, 1'b1);
  endtask

  int first_v;

  initial begin
    // Streaming after reset; also measure reset-to-first-valid latency.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    first_v = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (first_v < 0 && out_valid === 1'b1) first_v = i;
    end
    check("first_valid_cycle", first_v, 3);
    run(12, 1'b1);

    // Back-pressure: FIFO saturates, pc stops at 16, then drains in order.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    run(11, 1'b0);
    check("sat_pc", pc, 32'd16);
    run(8, 1'b1);

    // Redirect with three entries queued.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    run(4, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
    #1 check("redir_pc", pc, 32'h100);
    run(6, 1'b1);

    // Halt opcode at 0x8, then resume via redirect.
    halt_addr = 32'h8;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    run(10, 1'b1);
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_pc", pc, 32'hC);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    run(6, 1'b1);
    halt_addr = 32'h1;

    // PC wrap at the top of the address space, then a mid-stream reset.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    run(3, 1'b0);
    run(3, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    #1 check("midrst_valid", {31'b0, out_valid}, 32'h0);
    run(6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if (i % 250 == 0) halt_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                         : ($urandom & 32'h3FF);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, rpc,
           $urandom_range(0, 3) != 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
